// File: rtl/run_controller.sv
// Execution sequencer: debounces the front-panel buttons, runs the slow/fast
// advance dividers and issues advance/load pulses to the program counter.
module run_controller #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int SLOW_DIV  = 50_000_000,
  parameter int FAST_DIV  = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_run,
  input  logic       btn_speedrun,
  input  logic       halt,
  input  logic       jump_req,
  input  logic [7:0] jump_addr,
  input  logic [7:0] pc_in,
  input  logic       bp_en,
  input  logic [7:0] bp_addr,
  output logic       pc_advance,
  output logic       pc_load,
  output logic [7:0] pc_value,
  output logic [1:0] state,
  output logic       bp_hit
);

  localparam int DB_W = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [25:0] SLOW_LAST = 26'(SLOW_DIV - 1);
  localparam logic [25:0] FAST_LAST = 26'(FAST_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_RUN  = 2'd2,
    S_FAST = 2'd3
  } state_t;

  logic [2:0] btn_raw;
  logic [2:0] btn_p;
  logic [1:0] settle_q, settle_d;
  logic       settled;

  assign btn_raw = {btn_speedrun, btn_run, btn_next};
  assign settled = (settle_q == 2'd2);
  assign settle_d = settled ? settle_q : settle_q + 2'd1;

  // A button is armed only after it has been seen stably released, so a
  // button held through reset never produces a press.
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic            sync1_q, sync2_q;
    logic            level_q, level_d, level_prev_q;
    logic            armed_q, armed_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    always_comb begin
      level_d = level_q;
      armed_d = armed_q;
      cnt_d   = '0;
      if (!armed_q) begin
        if (settled && !sync2_q) begin
          if (cnt_q == DB_LAST) armed_d = 1'b1;
          else                  cnt_d = cnt_q + 1'b1;
        end
      end else if (sync2_q != level_q) begin
        if (cnt_q == DB_LAST) level_d = sync2_q;
        else                  cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q      <= 1'b0;
        sync2_q      <= 1'b0;
        level_q      <= 1'b0;
        level_prev_q <= 1'b0;
        armed_q      <= 1'b0;
        cnt_q        <= '0;
      end else begin
        sync1_q      <= btn_raw[gi];
        sync2_q      <= sync1_q;
        level_q      <= level_d;
        level_prev_q <= level_q;
        armed_q      <= armed_d;
        cnt_q        <= cnt_d;
      end
    end

    assign btn_p[gi] = level_q & ~level_prev_q;
  end

  logic       next_p, run_p, fast_p;
  state_t     state_q, state_d;
  logic [25:0] div_q, div_d, div_last;
  logic       pc_advance_q, pc_advance_d;
  logic       pc_load_q, pc_load_d;
  logic [7:0] pc_value_q, pc_value_d;
  logic       bp_hit_q, bp_hit_d;
  logic       chk_q, chk_d;
  logic       emit;
  logic       bp_match;

  assign next_p   = btn_p[0];
  assign run_p    = btn_p[1];
  assign fast_p   = btn_p[2];
  assign div_last = (state_q == S_FAST) ? FAST_LAST : SLOW_LAST;
  // chk_q marks the cycle where pc_in first shows the post-event count.
  assign bp_match = chk_q && bp_en && (pc_in == bp_addr);

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    pc_advance_d = 1'b0;
    pc_load_d    = 1'b0;
    pc_value_d   = pc_value_q;
    bp_hit_d     = 1'b0;
    chk_d        = pc_advance_q | pc_load_q;
    emit         = 1'b0;
    if (halt) begin
      state_d = S_IDLE;
      div_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          div_d = '0;
          if (fast_p)      state_d = S_FAST;
          else if (run_p)  state_d = S_RUN;
          else if (next_p) begin
            state_d = S_STEP;
            emit    = 1'b1;
          end
        end
        S_STEP: state_d = S_IDLE;
        default: begin
          if (bp_match) begin
            state_d  = S_IDLE;
            div_d    = '0;
            bp_hit_d = 1'b1;
          end else if (fast_p && state_q != S_FAST) begin
            state_d = S_FAST;
            div_d   = '0;
          end else if (run_p && state_q != S_RUN) begin
            state_d = S_RUN;
            div_d   = '0;
          end else if (next_p) begin
            state_d = S_IDLE;
            div_d   = '0;
          end else if (div_q == div_last) begin
            div_d = '0;
            emit  = 1'b1;
          end else begin
            div_d = div_q + 26'd1;
          end
        end
      endcase
    end
    if (emit) begin
      if (jump_req) begin
        pc_load_d  = 1'b1;
        pc_value_d = jump_addr;
      end else begin
        pc_advance_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q     <= 2'd0;
      state_q      <= S_IDLE;
      div_q        <= '0;
      pc_advance_q <= 1'b0;
      pc_load_q    <= 1'b0;
      pc_value_q   <= 8'd0;
      bp_hit_q     <= 1'b0;
      chk_q        <= 1'b0;
    end else begin
      settle_q     <= settle_d;
      state_q      <= state_d;
      div_q        <= div_d;
      pc_advance_q <= pc_advance_d;
      pc_load_q    <= pc_load_d;
      pc_value_q   <= pc_value_d;
      bp_hit_q     <= bp_hit_d;
      chk_q        <= chk_d;
    end
  end

  assign pc_advance = pc_advance_q;
  assign pc_load    = pc_load_q;
  assign pc_value   = pc_value_q;
  assign state      = state_q;
  assign bp_hit     = bp_hit_q;

endmodule
